// File: rtl/vr_stream_unpacker.sv
// vr_stream_unpacker: valid-ready down-converter, one IN_W word out as RATIO OUT_W beats, LSB chunk first
module vr_stream_unpacker #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int RATIO = IN_W / OUT_W,
  parameter int CNT_W = $clog2(RATIO)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             sync_rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  if (IN_W % OUT_W != 0 || RATIO < 2) begin : g_bad_params
    $error("vr_stream_unpacker: IN_W must be a multiple of OUT_W with RATIO >= 2");
  end
  logic [IN_W-1:0]  hold_data;
  logic             hold_last;
  logic             hold_valid;
  logic [CNT_W-1:0] beat_cnt;
  logic             last_beat;
  logic             in_shake;
  logic             out_shake;
  assign last_beat = beat_cnt == CNT_W'(RATIO - 1);
  assign in_ready  = en & ~sync_rst & (~hold_valid | (last_beat & out_ready));
  assign out_valid = en & hold_valid;
  assign out_data  = hold_data[OUT_W*int'(beat_cnt) +: OUT_W];
  assign out_last  = hold_valid & hold_last & last_beat;
  assign busy      = hold_valid;
  assign in_shake  = in_valid & in_ready;
  assign out_shake = out_valid & out_ready;
  // a load can only coincide with the final-beat drain, so it simply takes priority
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_valid <= 1'b0;
      beat_cnt   <= '0;
    end else if (sync_rst) begin
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_valid <= 1'b0;
      beat_cnt   <= '0;
    end else if (in_shake) begin
      hold_data  <= in_data;
      hold_last  <= in_last;
      hold_valid <= 1'b1;
      beat_cnt   <= '0;
    end else if (out_shake) begin
      hold_valid <= ~last_beat;
      beat_cnt   <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end
endmodule
